// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: row sense, column drive and encoded key output.
// master = scanner side (kp_row_n in; kp_col_n, key_code, key_valid out).
interface keypad_scanner_if;
  logic [3:0] kp_row_n;
  logic [3:0] kp_col_n;
  logic [3:0] key_code;
  logic       key_valid;

  modport master (
    input  kp_row_n,
    output kp_col_n,
    output key_code,
    output key_valid
  );

  modport slave (
    output kp_row_n,
    input  kp_col_n,
    input  key_code,
    input  key_valid
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, frame debounce, key encode, release gap.
// Ports: MAX10_CLK1_50, reset_n (async low), kp (keypad_scanner_if.master).
module keypad_scanner #(
  parameter int SCAN_TICKS      = 50000,
  parameter int DEBOUNCE_FRAMES = 10,
  parameter int MIN_GAP_CYCLES  = 50000
) (
  input  logic               MAX10_CLK1_50,
  input  logic               reset_n,
  keypad_scanner_if.master   kp
);

  localparam int DW = $clog2(SCAN_TICKS);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int GW = $clog2(MIN_GAP_CYCLES + 1);

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_FRAMES);
  localparam logic [GW-1:0] GAP_LAST   = GW'(MIN_GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    RES_NONE,
    RES_SINGLE,
    RES_MULTI
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [3:0] idx;
  } res_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_GAP
  } state_e;

  function automatic logic [3:0] code_of(logic [3:0] k);
    logic [3:0] c;
    case (k)
      4'd0:  c = 4'h1;
      4'd1:  c = 4'h2;
      4'd2:  c = 4'h3;
      4'd3:  c = 4'hA;
      4'd4:  c = 4'h4;
      4'd5:  c = 4'h5;
      4'd6:  c = 4'h6;
      4'd7:  c = 4'hB;
      4'd8:  c = 4'h7;
      4'd9:  c = 4'h8;
      4'd10: c = 4'h9;
      4'd11: c = 4'hC;
      4'd12: c = 4'hF;
      4'd13: c = 4'h0;
      4'd14: c = 4'hE;
      default: c = 4'hD;
    endcase
    return c;
  endfunction

  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    col_n_q, col_n_d;
  logic [15:0]   map_q, map_d;
  res_t          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;

  logic          sample;
  logic          frame_end;
  logic [15:0]   frame_map;
  logic [4:0]    ones;
  logic [3:0]    hit_idx;
  res_t          res_cur;
  logic [CW-1:0] cnt_new;
  logic          stable;

  // Column scan and frame accumulation
  always_comb begin
    sample    = (dwell_q == DWELL_LAST);
    frame_end = sample && (col_q == 2'd3);
    dwell_d   = sample ? '0 : dwell_q + DW'(1);
    col_d     = sample ? col_q + 2'd1 : col_q;
    col_n_d   = ~(4'b0001 << col_d);
    frame_map = map_q;
    for (int r = 0; r < 4; r++) begin
      if (sample && !row_s2_q[r])
        frame_map[{2'(r), col_q}] = 1'b1;
    end
    map_d = frame_end ? '0 : frame_map;
  end

  // Frame classification
  always_comb begin
    ones    = '0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame_map[4'(i)]) begin
        ones    = ones + 5'd1;
        hit_idx = 4'(i);
      end
    end
    res_cur.kind = (ones == 5'd0) ? RES_NONE :
                   (ones == 5'd1) ? RES_SINGLE : RES_MULTI;
    res_cur.idx  = (ones == 5'd1) ? hit_idx : 4'd0;
  end

  // Debounce: run length of identical frame results, saturating
  always_comb begin
    if (res_cur == prev_q)
      cnt_new = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    else
      cnt_new = CW'(1);
    stable = (cnt_new == CNT_MAX);
    prev_d = frame_end ? res_cur : prev_q;
    cnt_d  = frame_end ? cnt_new : cnt_q;
  end

  // Output FSM
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    code_d  = code_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (frame_end && stable &&
            res_cur.kind == RES_SINGLE) begin
          state_d = S_PRESSED;
          code_d  = code_of(res_cur.idx);
          valid_d = 1'b1;
        end
      end
      S_PRESSED: begin
        if (frame_end && stable &&
            res_cur.kind == RES_NONE) begin
          state_d = S_GAP;
          gap_d   = '0;
          valid_d = 1'b0;
        end
      end
      S_GAP: begin
        // Gap runs on clock cycles, not frames
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gap_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      dwell_q  <= '0;
      col_q    <= '0;
      col_n_q  <= 4'b1110;
      map_q    <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      state_q  <= S_IDLE;
      gap_q    <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      row_s1_q <= kp.kp_row_n;
      row_s2_q <= row_s1_q;
      dwell_q  <= dwell_d;
      col_q    <= col_d;
      col_n_q  <= col_n_d;
      map_q    <= map_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      gap_q    <= gap_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
    end
  end

  assign kp.kp_col_n  = col_n_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad model, frame-level reference, monitors.
// Small parameters: 4-cycle dwell, 3-frame debounce, 8-cycle gap.
module tb_keypad_scanner;

  localparam int ST = 4;
  localparam int DF = 3;
  localparam int MG = 8;
  localparam int FL = 4 * ST;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_scanner_if bus();

  keypad_scanner #(
    .SCAN_TICKS(ST),
    .DEBOUNCE_FRAMES(DF),
    .MIN_GAP_CYCLES(MG)
  ) dut (
    .MAX10_CLK1_50(clk),
    .reset_n(rst_n),
    .kp(bus)
  );

  logic [15:0] held = '0;
  logic [3:0]  rows;

  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[4*r+c] && !bus.kp_col_n[c]) rows[r] = 1'b0;
  end
  assign bus.kp_row_n = rows;

  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0] lay [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                           4'h4, 4'h5, 4'h6, 4'hB,
                           4'h7, 4'h8, 4'h9, 4'hC,
                           4'hF, 4'h0, 4'hE, 4'hD};

  // Reference: one step per scan frame; -1 none, -2 multi, else key index
  int         m_prev;
  int         m_cnt;
  logic       m_valid;
  logic [3:0] m_code;

  function automatic int classify(logic [15:0] h);
    int n;
    n = $countones(h);
    if (n == 0) return -1;
    if (n > 1) return -2;
    for (int i = 0; i < 16; i++) if (h[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_prev = -1; m_cnt = 0; m_valid = 1'b0; m_code = 4'h0;
  endtask

  task automatic model_step(int res);
    if (res == m_prev) m_cnt = (m_cnt < DF) ? m_cnt + 1 : DF;
    else m_cnt = 1;
    m_prev = res;
    if (m_cnt == DF) begin
      if (!m_valid && res >= 0) begin
        m_valid = 1'b1;
        m_code  = lay[res];
      end else if (m_valid && res == -1) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic next_frame();
    do begin
      @(posedge clk); #1;
    end while (cyc % FL != 0);
  endtask

  task automatic run_frame();
    next_frame();
    model_step(classify(held));
  endtask

  // Continuous monitors: code held while valid, minimum low time
  logic       pv_q = 1'b0;
  logic [3:0] pc_q = 4'h0;
  int         low_q = 0;
  logic       fell_q = 1'b0;

  always @(negedge clk) begin
    if (pv_q && bus.key_valid) begin
      n_chk++;
      if (bus.key_code !== pc_q) begin
        n_fail++;
        $display("FAIL code_hold: key_code=%h, was %h while valid",
                 bus.key_code, pc_q);
      end
    end
    if (!pv_q && bus.key_valid && fell_q) begin
      n_chk++;
      if (low_q < MG) begin
        n_fail++;
        $display("FAIL min_gap: low for %0d cycles, need >= %0d",
                 low_q, MG);
      end
    end
    low_q <= bus.key_valid ? 0 : low_q + 1;
    if (pv_q && !bus.key_valid) fell_q <= 1'b1;
    pv_q <= bus.key_valid;
    pc_q <= bus.key_code;
  end

  task automatic test_reset();
    logic [3:0] e;
    held  = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.kp_col_n !== 4'b1110) begin
      n_fail++;
      $display("FAIL rst_col: got %b expected 1110", bus.kp_col_n);
    end
    n_chk++;
    if (bus.key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid: got %b expected 0", bus.key_valid);
    end
    n_chk++;
    if (bus.key_code !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_code: got %h expected 0", bus.key_code);
    end
    rst_n = 1'b1;
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      e = ~(4'b0001 << ((cyc / ST) % 4));
      n_chk++;
      if (bus.kp_col_n !== e) begin
        n_fail++;
        $display("FAIL scan: cyc %0d col_n=%b expected %b",
                 cyc, bus.kp_col_n, e);
      end
    end
    model_step(classify(held));
  endtask

  task automatic test_clean_press();
    int lat;
    repeat ($urandom_range(0, FL - 1)) @(posedge clk);
    #1;
    held = 16'(1) << 6;
    lat = 0;
    while (!bus.key_valid && lat < 70) begin
      @(posedge clk); #1; lat++;
    end
    n_chk++;
    if (!bus.key_valid || lat > 66 || bus.key_code !== 4'h6) begin
      n_fail++;
      $display("FAIL press6: valid=%b code=%h after %0d cyc, need 1/6 by 66",
               bus.key_valid, bus.key_code, lat);
    end
    repeat (6 * FL - lat) @(posedge clk);
    #1;
    n_chk++;
    if (bus.key_valid !== 1'b1 || bus.key_code !== 4'h6) begin
      n_fail++;
      $display("FAIL hold6: valid=%b code=%h expected 1/6",
               bus.key_valid, bus.key_code);
    end
    repeat ($urandom_range(0, FL - 1)) @(posedge clk);
    #1;
    held = '0;
    lat = 0;
    while (bus.key_valid && lat < 70) begin
      @(posedge clk); #1; lat++;
    end
    n_chk++;
    if (bus.key_valid || lat > 66) begin
      n_fail++;
      $display("FAIL release6: valid=%b after %0d cyc, need 0 by 66",
               bus.key_valid, lat);
    end
    // Fall lands on a frame end with NONE already stable
    m_prev = -1; m_cnt = DF; m_valid = 1'b0; m_code = 4'h6;
    for (int i = 0; i < 2; i++) begin
      run_frame();
      n_chk++;
      if (bus.key_valid !== m_valid || bus.key_code !== m_code) begin
        n_fail++;
        $display("FAIL idle6: got %b/%h expected %b/%h",
                 bus.key_valid, bus.key_code, m_valid, m_code);
      end
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 10; i++) begin
      held = (i % 2 == 0) ? (16'(1) << 5) : 16'h0;
      run_frame();
      n_chk++;
      if (bus.key_valid !== 1'b0 || bus.key_valid !== m_valid ||
          bus.key_code !== m_code) begin
        n_fail++;
        $display("FAIL bounce: frame %0d got %b/%h expected %b/%h",
                 i, bus.key_valid, bus.key_code, m_valid, m_code);
      end
    end
    held = '0;
    repeat (2) run_frame();
  endtask

  task automatic test_gap_codes();
    held = 16'(1) << 12;
    for (int i = 0; i < 4; i++) begin
      run_frame();
      n_chk++;
      if (bus.key_valid !== m_valid || bus.key_code !== m_code) begin
        n_fail++;
        $display("FAIL star: got %b/%h expected %b/%h",
                 bus.key_valid, bus.key_code, m_valid, m_code);
      end
    end
    n_chk++;
    if (bus.key_code !== 4'hF) begin
      n_fail++;
      $display("FAIL star_code: got %h expected F", bus.key_code);
    end
    held = '0;
    for (int i = 0; i < 5; i++) begin
      run_frame();
      n_chk++;
      if (bus.key_valid !== m_valid || bus.key_code !== m_code) begin
        n_fail++;
        $display("FAIL star_rel: got %b/%h expected %b/%h",
                 bus.key_valid, bus.key_code, m_valid, m_code);
      end
      if (!m_valid) break;
    end
    held = 16'(1) << 14;
    for (int i = 0; i < 4; i++) begin
      run_frame();
      n_chk++;
      if (bus.key_valid !== m_valid || bus.key_code !== m_code) begin
        n_fail++;
        $display("FAIL hash: got %b/%h expected %b/%h",
                 bus.key_valid, bus.key_code, m_valid, m_code);
      end
    end
    n_chk++;
    if (bus.key_valid !== 1'b1 || bus.key_code !== 4'hE) begin
      n_fail++;
      $display("FAIL hash_code: got %b/%h expected 1/E",
               bus.key_valid, bus.key_code);
    end
    held = '0;
    repeat (4) run_frame();
  endtask

  task automatic test_multi();
    held = 16'(1) | (16'(1) << 10);
    for (int i = 0; i < 6; i++) begin
      run_frame();
      n_chk++;
      if (bus.key_valid !== 1'b0 || bus.key_valid !== m_valid) begin
        n_fail++;
        $display("FAIL multi19: valid=%b expected 0", bus.key_valid);
      end
    end
    held = 16'(1) << 4;
    repeat (3) run_frame();
    n_chk++;
    if (bus.key_valid !== 1'b1 || bus.key_code !== 4'h4 ||
        m_code !== 4'h4) begin
      n_fail++;
      $display("FAIL press4: got %b/%h expected 1/4",
               bus.key_valid, bus.key_code);
    end
    held = held | (16'(1) << 8);
    for (int i = 0; i < 6; i++) begin
      run_frame();
      n_chk++;
      if (bus.key_valid !== 1'b1 || bus.key_code !== 4'h4) begin
        n_fail++;
        $display("FAIL rollover: got %b/%h expected 1/4",
                 bus.key_valid, bus.key_code);
      end
    end
    held = '0;
    repeat (4) run_frame();
  endtask

  task automatic test_reset_mid();
    held = 16'(1) << 13;
    for (int i = 0; i < 4; i++) begin
      run_frame();
      n_chk++;
      if (bus.key_valid !== m_valid || bus.key_code !== m_code) begin
        n_fail++;
        $display("FAIL press0: got %b/%h expected %b/%h",
                 bus.key_valid, bus.key_code, m_valid, m_code);
      end
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.key_valid !== 1'b0 || bus.key_code !== 4'h0 ||
        bus.kp_col_n !== 4'b1110) begin
      n_fail++;
      $display("FAIL async_rst: got %b/%h/%b expected 0/0/1110",
               bus.key_valid, bus.key_code, bus.kp_col_n);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_frame();
      n_chk++;
      if (bus.key_valid !== m_valid || bus.key_code !== m_code) begin
        n_fail++;
        $display("FAIL reacquire: frame %0d got %b/%h expected %b/%h",
                 i, bus.key_valid, bus.key_code, m_valid, m_code);
      end
    end
    held = '0;
    repeat (4) run_frame();
  endtask

  task automatic test_random();
    int kind, a, b, len;
    for (int s = 0; s < 25; s++) begin
      kind = $urandom_range(0, 3);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      len = $urandom_range(1, 5);
      case (kind)
        0: held = '0;
        3: held = (16'(1) << a) | (16'(1) << b);
        default: held = 16'(1) << a;
      endcase
      for (int f = 0; f < len; f++) begin
        run_frame();
        n_chk++;
        if (bus.key_valid !== m_valid || bus.key_code !== m_code) begin
          n_fail++;
          $display("FAIL random: seg %0d keys %h got %b/%h expected %b/%h",
                   s, held, bus.key_valid, bus.key_code, m_valid, m_code);
        end
      end
    end
    held = '0;
    repeat (4) run_frame();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_gap_codes();
    test_multi();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 membrane keypad on the keyboard DE-10 board, debounces it, and encodes the pressed key into a 4-bit code plus a valid level. It is the stage directly upstream of the vault combination controller. The top level routes `key_valid` to ARDUINO_IO[12] and `key_code` to ARDUINO_IO[11:8]. The downstream board double-synchronises both signals, so `key_code` must be stable whenever `key_valid` is high.

## Interface
- SCAN_TICKS, 50000: clock cycles each column is driven (1 ms at 50 MHz); ≥2.
- DEBOUNCE_FRAMES, 10: consecutive identical scan-frame results required to accept a change; ≥2.
- MIN_GAP_CYCLES, 50000: minimum `key_valid` low time after a release; ≥1.

- MAX10_CLK1_50  in   1  system clock, 50 MHz.
- reset_n        in   1  asynchronous, active-low reset.
- kp_row_n       in   4  keypad rows, pulled up, low = contact; asynchronous.
- kp_col_n       out  4  one-cold column drive.
- key_code       out  4  encoded key; held while `key_valid` is high.
- key_valid      out  1  high while a debounced single key is held.

## Operation
- **Row input**: `kp_row_n` passes through a 2-flop synchroniser. Both flops reset to 4'b1111.
- **Column scan**:
  - A column index 0..3 and a dwell counter 0..SCAN_TICKS-1 run continuously.
  - `kp_col_n` drives bit[index] low and all other bits high.
  - Synchronised rows are sampled on the last dwell cycle of each column. The index then increments and wraps 3→0.
- **Frame accumulator**: 16-bit key map; bit (4*row+col) is set when that row reads low while that column is driven.
- **Frame end**: occurs on the column-3 sample cycle. The map is classified, then cleared:
  - NONE: popcount 0.
  - SINGLE(k): popcount 1, with k the key index.
  - MULTI: popcount >1.
- **Debounce**:
  - If the current frame result equals the previous one, the count increments, saturating at DEBOUNCE_FRAMES. Otherwise the count resets to 1.
  - The result is "stable" when the count equals DEBOUNCE_FRAMES.
  - Reset state: previous result = NONE, count = 0.
- **Layout → code** (rows r0..r3, columns c0..c3):
  - r0: 1 2 3 A → 1, 2, 3, A
  - r1: 4 5 6 B → 4, 5, 6, B
  - r2: 7 8 9 C → 7, 8, 9, C
  - r3: * 0 # D → F, 0, E, D
- **FSM** (evaluated at frame end unless noted):
  - IDLE (`key_valid`=0): on stable SINGLE(k), load `key_code` with code(k) and go to PRESSED. Stable NONE and stable MULTI stay in IDLE.
  - PRESSED (`key_valid`=1): on stable NONE, go to GAP. Stable MULTI, or stable SINGLE of a different key, stays in PRESSED with `key_code` unchanged (no rollover).
  - GAP (`key_valid`=0): counts MIN_GAP_CYCLES clock cycles independently of frame end, then goes to IDLE. A key held through GAP is accepted in IDLE at the next frame end where the result is still stable.
- `key_code` changes only on the IDLE→PRESSED transition. It keeps its last value in GAP and IDLE.

## Timing
- **Reset values**:
  - `kp_col_n` = 4'b1110
  - `key_valid` = 0
  - `key_code` = 4'h0
  - FSM = IDLE
  - dwell counter = 0, column index = 0
  - frame map = 0, debounce state as above, gap counter = 0
- **Asynchronous reset mid-operation**: all outputs take their reset values immediately. A held key must then pass a full DEBOUNCE_FRAMES again.
- **Frame length**: 4*SCAN_TICKS cycles.
- **Press latency**: `key_valid` and `key_code` update together, in the cycle after the frame end on which the count reaches DEBOUNCE_FRAMES.
  - Worst case from a clean press: 2 sync cycles + up to 1 partial frame + DEBOUNCE_FRAMES frames.
- **Release latency**: the same bound, measured to the `key_valid` fall.
- **Output stability**:
  - `key_code` is stable at least 1 cycle before `key_valid` rises, or changes in the same cycle.
  - `key_code` never changes while `key_valid` = 1.
- **Minimum low pulse**: `key_valid` is low for at least MIN_GAP_CYCLES cycles between presses.
- All outputs are registered. There is no combinational path from `kp_row_n` to any output.

## Test plan
Parameters: SCAN_TICKS=4, DEBOUNCE_FRAMES=3, MIN_GAP_CYCLES=8 (frame = 16 cycles). Bench keypad model: row r pulled low whenever a held key's column is driven low.

1. **Reset and scan**: assert `reset_n`=0, then release.
   - While reset is low: `kp_col_n`=1110, `key_valid`=0, `key_code`=0.
   - After release, `kp_col_n` steps 1101, 1011, 0111, 1110 every 4 cycles.
2. **Clean press**: hold key 6 (r1, c2) for 6 frames.
   - `key_valid` rises with `key_code`=6 within 2+16+48 cycles of the press.
   - `key_code` stays at 6 until release.
   - After release, `key_valid` falls within 66 cycles.
3. **Bounce**: toggle key 5 on/off on alternate frames for 10 frames.
   - `key_valid` stays 0 throughout.
4. **Gap and codes**: press `*` and expect `key_code`=F. Release, then press `#` on the cycle `key_valid` falls.
   - `key_valid` stays low for ≥8 cycles.
   - `key_valid` rises again with `key_code`=E.
5. **Multi-key and no rollover**:
   - Press 1 and 9 together for 6 frames: `key_valid` stays 0.
   - Hold 4 until valid (`key_code`=4), then add 7 for 6 frames: `key_code` stays 4 and `key_valid` stays 1.
6. **Reset mid-press**: pulse `reset_n` low while key 0 is held and valid.
   - Outputs clear without waiting for a clock edge.
   - `key_valid` re-rises with `key_code`=0 only after 3 full stable frames.
